crossbar_out_arbiter: RTL and testbench
=======================================

Name: crossbar_out_arbiter

Overview:
- Output-side stage of the crossbar, directly downstream of the per-destination crossbar points.
- Each of P_NUM_IN points for one egress port raises a transmit request. This block grants exactly one point at a time, round-robin.
- It forwards that point's AXI-Stream packet to the single egress port and holds the lock until the packet's tlast beat handshakes, or until a watchdog expires.

Parameters:
- P_NUM_IN, 8, number of crossbar points (ingress sources) competing for this egress port; 2..8.
- P_TIMEOUT, 16'd64, cycles allowed from grant pulse to first selected tvalid before the lock is abandoned.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_trans_req  in  P_NUM_IN  per-point request; held high until granted
- o_trans_grant  out  P_NUM_IN  one-hot, single-cycle grant pulse
- s_axis_rx_tvalid  in  P_NUM_IN  per-point valid
- s_axis_rx_tdata  in  64*P_NUM_IN  per-point data; point k uses bits [64k+63:64k]
- s_axis_rx_tlast  in  P_NUM_IN  per-point last
- s_axis_rx_tkeep  in  8*P_NUM_IN  per-point keep; point k uses bits [8k+7:8k]
- s_axis_rx_tuser  in  P_NUM_IN  per-point user
- s_axis_rx_tready  out  P_NUM_IN  per-point ready
- m_axis_tx_tvalid  out  1  egress valid
- m_axis_tx_tdata  out  64  egress data
- m_axis_tx_tlast  out  1  egress last
- m_axis_tx_tkeep  out  8  egress keep
- m_axis_tx_tuser  out  1  egress user
- m_axis_tx_tready  in  1  egress ready
- o_timeout_err  out  1  single-cycle pulse when the watchdog releases a lock

Behaviour:
- Reset values: o_trans_grant=0, o_timeout_err=0, s_axis_rx_tready=0, m_axis_tx_tvalid=0, m_axis_tx_tlast=0, m_axis_tx_tdata=0, m_axis_tx_tkeep=0, m_axis_tx_tuser=0. Internally: state=IDLE, rr pointer=0, sel=0, watchdog=0.
- Round-robin: the pointer names the highest-priority index. Search runs ptr, ptr+1, …, wrapping modulo P_NUM_IN. When a grant is issued, ptr <= sel+1 (mod P_NUM_IN).
- FSM states:
  - IDLE: if any i_trans_req, latch sel = first requester from ptr, go to GRANT. Otherwise stay.
  - GRANT: o_trans_grant[sel]=1 for exactly this one registered cycle. Clear watchdog, go to WAIT.
  - WAIT: if s_axis_rx_tvalid[sel], go to XFER. The same cycle's beat is passed through combinationally, and if it handshakes with tlast, return directly to IDLE. Else if watchdog == P_TIMEOUT-1, pulse o_timeout_err and go to IDLE. Else watchdog+1.
  - XFER: on m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast, go to IDLE. Otherwise stay; no timeout applies in XFER.
- Datapath, combinational and zero-latency, only in WAIT/XFER:
  - m_axis_tx_{tvalid,tdata,tlast,tkeep,tuser} = selected point's signals.
  - s_axis_rx_tready[sel] = m_axis_tx_tready; every other tready = 0.
  - In IDLE/GRANT: m_axis_tx_tvalid=0, tlast=0, all s_axis_rx_tready=0, and tdata/tkeep/tuser are forced to 0.
- Requests:
  - i_trans_req is sampled only in IDLE.
  - A point drops its request the cycle after its grant, so a request still high during GRANT/WAIT must not cause a second grant.
  - Minimum request-to-grant latency: 2 cycles (IDLE sample edge, then GRANT cycle).
- Stray inputs: tvalid from a non-selected point is ignored and never reaches egress. That point's tready stays 0, so its beat is held at the source, not dropped.
- Back-to-back packets: the return to IDLE costs 1 cycle, so the minimum gap between egress packets is 2 idle cycles (IDLE, GRANT).
- Single-beat packet (tvalid & tlast on first beat): accepted in WAIT, FSM goes straight to IDLE.
- Watchdog: 16-bit, saturates harmlessly. P_TIMEOUT=0 is illegal.
- Reset mid-transfer: all outputs return to reset values asynchronously, FSM goes to IDLE, ptr=0. The partial packet is truncated, and no tlast is generated for it.

Test Plan:
- Single packet, no backpressure: req[3] high at cycle 0 → grant[3] pulse at cycle 2 only; a 4-beat packet with tkeep=8'h0F on the last beat appears on egress unchanged; FSM is back in IDLE after the tlast handshake.
- Contention: req[0], req[2], req[5] high together with ptr=0 → grant order 0, 2, 5; a new req[0] arriving during packet 5 is granted before any index below 5 is revisited, i.e. after 6, 7 are checked.
- Egress backpressure: m_axis_tx_tready toggles 1,0,0,1 during a 6-beat packet → s_axis_rx_tready[sel] mirrors it exactly; no beat is duplicated or lost; non-selected treadies stay 0.
- Timeout: grant[1] issued and point 1 never asserts tvalid → o_timeout_err pulses exactly 64 cycles after the grant cycle; the next pending req[2] is granted 2 cycles later.
- Stray valid: during a packet from point 4, point 6 holds tvalid=1 → egress carries only point 4's data; point 6's beat is delivered after point 6 is later granted.
- Reset mid-packet: assert i_rst after beat 2 of 8 → m_axis_tx_tvalid=0 immediately; after release, req[7] is granted in 2 cycles with ptr restarted at 0.

Source files
------------

// File: rtl/crossbar_out_arbiter_if.sv
// Bus bundle between the per-destination crossbar points and the egress arbiter.
// Carries the request/grant handshake, the P_NUM_IN packed AXI-Stream ingress
// lanes, the single AXI-Stream egress lane and the watchdog error pulse.
// master: the arbiter side. slave: the crossbar points plus the egress sink.
interface crossbar_out_arbiter_if #(
  parameter int unsigned P_NUM_IN = 8
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;

  logic [P_NUM_IN-1:0]        i_trans_req;
  logic [P_NUM_IN-1:0]        o_trans_grant;
  logic [P_NUM_IN-1:0]        s_axis_rx_tvalid;
  logic [DATA_W*P_NUM_IN-1:0] s_axis_rx_tdata;
  logic [P_NUM_IN-1:0]        s_axis_rx_tlast;
  logic [KEEP_W*P_NUM_IN-1:0] s_axis_rx_tkeep;
  logic [P_NUM_IN-1:0]        s_axis_rx_tuser;
  logic [P_NUM_IN-1:0]        s_axis_rx_tready;
  logic                       m_axis_tx_tvalid;
  logic [DATA_W-1:0]          m_axis_tx_tdata;
  logic                       m_axis_tx_tlast;
  logic [KEEP_W-1:0]          m_axis_tx_tkeep;
  logic                       m_axis_tx_tuser;
  logic                       m_axis_tx_tready;
  logic                       o_timeout_err;

  modport master (
    input  i_trans_req,
    output o_trans_grant,
    input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tlast,
    input  s_axis_rx_tkeep, s_axis_rx_tuser,
    output s_axis_rx_tready,
    output m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast,
    output m_axis_tx_tkeep, m_axis_tx_tuser,
    input  m_axis_tx_tready,
    output o_timeout_err
  );

  modport slave (
    output i_trans_req,
    input  o_trans_grant,
    output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tlast,
    output s_axis_rx_tkeep, s_axis_rx_tuser,
    input  s_axis_rx_tready,
    input  m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast,
    input  m_axis_tx_tkeep, m_axis_tx_tuser,
    output m_axis_tx_tready,
    input  o_timeout_err
  );
endinterface

// File: rtl/crossbar_out_arbiter.sv
// Egress-side round-robin arbiter of the crossbar. Grants one crossbar point at
// a time, forwards its AXI-Stream packet to the egress port with zero latency
// and keeps the lock until the tlast beat handshakes or the first-beat
// watchdog expires.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (master) : request/grant, P_NUM_IN ingress lanes, egress lane,
//                  o_timeout_err pulse
module crossbar_out_arbiter #(
  parameter int unsigned P_NUM_IN  = 8,
  parameter logic [15:0] P_TIMEOUT = 16'd64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  crossbar_out_arbiter_if.master  bus
);
  localparam int unsigned IDX_W  = (P_NUM_IN > 1) ? $clog2(P_NUM_IN) : 1;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned WD_W   = 16;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_XFER} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic              req_found;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  scan_idx;
  int unsigned       scan_pos;
  logic              sel_valid;
  logic              sel_hs_last;

  // Round-robin search: first requester at or after ptr_q, wrapping.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < P_NUM_IN; i++) begin
      scan_pos = 32'(ptr_q) + i;
      if (scan_pos >= P_NUM_IN) scan_pos = scan_pos - P_NUM_IN;
      scan_idx = IDX_W'(scan_pos);
      if (!req_found && bus.i_trans_req[scan_idx]) begin
        req_found = 1'b1;
        req_idx   = scan_idx;
      end
    end
  end

  // State, pointer, selection and watchdog registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic plus the zero-latency egress mux.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    wd_d      = wd_q;

    bus.o_trans_grant    = '0;
    bus.o_timeout_err    = 1'b0;
    bus.s_axis_rx_tready = '0;
    bus.m_axis_tx_tvalid = 1'b0;
    bus.m_axis_tx_tdata  = '0;
    bus.m_axis_tx_tlast  = 1'b0;
    bus.m_axis_tx_tkeep  = '0;
    bus.m_axis_tx_tuser  = 1'b0;

    sel_valid   = bus.s_axis_rx_tvalid[sel_q];
    sel_hs_last = sel_valid & bus.m_axis_tx_tready & bus.s_axis_rx_tlast[sel_q];

    // The locked point owns the egress lane only while a packet may be in flight.
    if (state_q == S_WAIT || state_q == S_XFER) begin
      bus.m_axis_tx_tvalid        = sel_valid;
      bus.m_axis_tx_tdata         = bus.s_axis_rx_tdata[32'(sel_q) * DATA_W +: DATA_W];
      bus.m_axis_tx_tlast         = bus.s_axis_rx_tlast[sel_q];
      bus.m_axis_tx_tkeep         = bus.s_axis_rx_tkeep[32'(sel_q) * KEEP_W +: KEEP_W];
      bus.m_axis_tx_tuser         = bus.s_axis_rx_tuser[sel_q];
      bus.s_axis_rx_tready[sel_q] = bus.m_axis_tx_tready;
    end

    case (state_q)
      S_IDLE: begin
        if (req_found) begin
          sel_d   = req_idx;
          ptr_d   = (32'(req_idx) == P_NUM_IN - 1) ? '0 : req_idx + IDX_W'(1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        bus.o_trans_grant[sel_q] = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A single-beat packet completes here and skips XFER.
        if (sel_valid) begin
          state_d = sel_hs_last ? S_IDLE : S_XFER;
        end else if (wd_q == P_TIMEOUT - 16'd1) begin
          bus.o_timeout_err = 1'b1;
          state_d           = S_IDLE;
        end else if (wd_q != {WD_W{1'b1}}) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_XFER: begin
        if (sel_hs_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_crossbar_out_arbiter.sv
// Directed bench for crossbar_out_arbiter: single packet, contention order,
// egress backpressure, watchdog timeout, stray valid and reset mid-packet.
module tb_crossbar_out_arbiter;
  localparam int unsigned N = 8;

  logic i_clk;
  logic i_rst;
  int   total;
  int   bad;

  crossbar_out_arbiter_if #(.P_NUM_IN(N)) bus ();

  crossbar_out_arbiter #(.P_NUM_IN(N), .P_TIMEOUT(16'd64)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pt(input int k, input logic v, input logic [63:0] d,
                          input logic l, input logic [7:0] kp, input logic u);
    bus.s_axis_rx_tvalid[k]       = v;
    bus.s_axis_rx_tdata[64*k +: 64] = d;
    bus.s_axis_rx_tlast[k]        = l;
    bus.s_axis_rx_tkeep[8*k +: 8] = kp;
    bus.s_axis_rx_tuser[k]        = u;
  endtask

  // From IDLE with the request already raised: GRANT cycle then first WAIT cycle.
  task automatic grant_step(input string tag, input logic [7:0] exp);
    cyc();
    chk(tag, 64'(bus.o_trans_grant), 64'(exp));
    chk("grant_no_egress", 64'(bus.m_axis_tx_tvalid), 64'd0);
    bus.i_trans_req = bus.i_trans_req & ~exp;
    cyc();
    chk("grant_one_cycle", 64'(bus.o_trans_grant), 64'd0);
  endtask

  // Entered in WAIT with egress ready high; ends in IDLE with the source idle.
  task automatic pkt(input int k, input int nb, input logic [63:0] base);
    logic last;
    logic [7:0] kp;
    logic [7:0] rdy;
    for (int b = 0; b < nb; b++) begin
      last = (b == nb - 1);
      kp   = last ? 8'h0F : 8'hFF;
      drive_pt(k, 1'b1, base + 64'(b), last, kp, b[0]);
      #1;
      rdy = 8'd1 << k;
      chk("pkt_valid", 64'(bus.m_axis_tx_tvalid), 64'd1);
      chk("pkt_data",  bus.m_axis_tx_tdata, base + 64'(b));
      chk("pkt_last",  64'(bus.m_axis_tx_tlast), 64'(last));
      chk("pkt_keep",  64'(bus.m_axis_tx_tkeep), 64'(kp));
      chk("pkt_user",  64'(bus.m_axis_tx_tuser), 64'(b[0]));
      chk("pkt_ready", 64'(bus.s_axis_rx_tready), 64'(rdy));
      cyc();
    end
    drive_pt(k, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("pkt_back_idle", 64'(bus.m_axis_tx_tvalid), 64'd0);
  endtask

  initial begin
    logic [8:0]  pat;
    logic        rdy;
    int          b;
    total = 0;
    bad   = 0;
    i_rst = 1'b1;
    bus.i_trans_req      = '0;
    bus.s_axis_rx_tvalid = '0;
    bus.s_axis_rx_tdata  = '0;
    bus.s_axis_rx_tlast  = '0;
    bus.s_axis_rx_tkeep  = '0;
    bus.s_axis_rx_tuser  = '0;
    bus.m_axis_tx_tready = 1'b1;

    // Reset values.
    cyc();
    cyc();
    chk("rst_grant",  64'(bus.o_trans_grant), 64'd0);
    chk("rst_tmo",    64'(bus.o_timeout_err), 64'd0);
    chk("rst_rready", 64'(bus.s_axis_rx_tready), 64'd0);
    chk("rst_tvalid", 64'(bus.m_axis_tx_tvalid), 64'd0);
    chk("rst_tdata",  bus.m_axis_tx_tdata, 64'd0);
    chk("rst_tkeep",  64'(bus.m_axis_tx_tkeep), 64'd0);
    i_rst = 1'b0;

    // Single 4-beat packet from point 3, request held through GRANT.
    bus.i_trans_req[3] = 1'b1;
    #1;
    chk("s1_no_early_grant", 64'(bus.o_trans_grant), 64'd0);
    grant_step("s1_grant3", 8'h08);
    pkt(3, 4, 64'hA000_0000_0000_0000);

    // Contention from ptr=0: 0, 2, 5, then 7, 0, 3 raised during packet 5.
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    bus.i_trans_req = 8'b0010_0101;
    grant_step("s2_grant0", 8'h01);
    pkt(0, 1, 64'h0000_0000_0000_0100);
    grant_step("s2_grant2", 8'h04);
    pkt(2, 2, 64'h0000_0000_0000_0200);
    grant_step("s2_grant5", 8'h20);
    bus.i_trans_req = bus.i_trans_req | 8'h89;
    pkt(5, 3, 64'h0000_0000_0000_0500);
    grant_step("s2_grant7", 8'h80);
    pkt(7, 1, 64'h0000_0000_0000_0700);
    grant_step("s2_grant0b", 8'h01);
    pkt(0, 1, 64'h0000_0000_0000_0101);
    grant_step("s2_grant3", 8'h08);
    pkt(3, 1, 64'h0000_0000_0000_0300);

    // Backpressure on a 6-beat packet from point 4 (ptr is 4).
    bus.i_trans_req[4] = 1'b1;
    grant_step("s3_grant4", 8'h10);
    pat = 9'b1_1111_1001;
    b = 0;
    for (int c = 0; c < 16 && b < 6; c++) begin
      rdy = (c < 9) ? pat[c] : 1'b1;
      bus.m_axis_tx_tready = rdy;
      drive_pt(4, 1'b1, 64'hB000 + 64'(b), (b == 5), 8'hFF, 1'b0);
      #1;
      chk("s3_rready", 64'(bus.s_axis_rx_tready), rdy ? 64'h10 : 64'h00);
      chk("s3_data",   bus.m_axis_tx_tdata, 64'hB000 + 64'(b));
      chk("s3_valid",  64'(bus.m_axis_tx_tvalid), 64'd1);
      if (rdy) b++;
      cyc();
    end
    chk("s3_beats", 64'(b), 64'd6);
    bus.m_axis_tx_tready = 1'b1;
    drive_pt(4, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("s3_back_idle", 64'(bus.m_axis_tx_tvalid), 64'd0);

    // Timeout: ptr=5, requests 1 and 2 -> 1 granted and stays silent.
    bus.i_trans_req = 8'h06;
    grant_step("s4_grant1", 8'h02);
    for (int c = 1; c <= 64; c++) begin
      chk("s4_tmo", 64'(bus.o_timeout_err), 64'(c == 64));
      cyc();
    end
    chk("s4_tmo_off", 64'(bus.o_timeout_err), 64'd0);
    chk("s4_idle_grant", 64'(bus.o_trans_grant), 64'd0);
    grant_step("s4_grant2", 8'h04);
    pkt(2, 1, 64'h0000_0000_0000_0201);

    // Stray valid from point 6 while point 4 owns the egress (ptr is 3).
    drive_pt(6, 1'b1, 64'h0666, 1'b1, 8'hFF, 1'b1);
    #1;
    chk("s5_idle_valid", 64'(bus.m_axis_tx_tvalid), 64'd0);
    chk("s5_idle_data",  bus.m_axis_tx_tdata, 64'd0);
    chk("s5_idle_ready", 64'(bus.s_axis_rx_tready), 64'd0);
    bus.i_trans_req[4] = 1'b1;
    grant_step("s5_grant4", 8'h10);
    pkt(4, 3, 64'hC000);
    bus.i_trans_req[6] = 1'b1;
    grant_step("s5_grant6", 8'h40);
    chk("s5_held_data",  bus.m_axis_tx_tdata, 64'h0666);
    chk("s5_held_last",  64'(bus.m_axis_tx_tlast), 64'd1);
    chk("s5_held_ready", 64'(bus.s_axis_rx_tready), 64'h40);
    cyc();
    drive_pt(6, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0);
    #1;
    chk("s5_back_idle", 64'(bus.m_axis_tx_tvalid), 64'd0);

    // Reset during beat 3 of an 8-beat packet from point 5.
    bus.i_trans_req[5] = 1'b1;
    grant_step("s6_grant5", 8'h20);
    for (int k = 0; k < 2; k++) begin
      drive_pt(5, 1'b1, 64'hD000 + 64'(k), 1'b0, 8'hFF, 1'b0);
      cyc();
    end
    drive_pt(5, 1'b1, 64'hD002, 1'b0, 8'hFF, 1'b0);
    #1;
    chk("s6_pre_valid", 64'(bus.m_axis_tx_tvalid), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("s6_rst_valid", 64'(bus.m_axis_tx_tvalid), 64'd0);
    chk("s6_rst_data",  bus.m_axis_tx_tdata, 64'd0);
    chk("s6_rst_last",  64'(bus.m_axis_tx_tlast), 64'd0);
    chk("s6_rst_ready", 64'(bus.s_axis_rx_tready), 64'd0);
    cyc();
    i_rst = 1'b0;
    drive_pt(5, 1'b0, 64'd0, 1'b0, 8'd0, 1'b0);
    bus.i_trans_req[7] = 1'b1;
    #1;
    chk("s6_no_early_grant", 64'(bus.o_trans_grant), 64'd0);
    grant_step("s6_grant7", 8'h80);
    pkt(7, 1, 64'hE000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
